// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. Two WIDTH-bit operands are streamed LSB-first
// through one full-adder cell plus a carry flop, one bit per clock.
// A start/done handshake faces the controller; sum/cout are only updated on
// completion, so partial results never appear on the outputs.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   defined   -> adds input port 'sub'; sub=1 computes a-b (b inverted on load,
//                carry loaded with 1, cin ignored); cout=1 means no borrow.
//   undefined -> add only, no 'sub' port. Timing is identical in both builds.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; sum/cout hold the last completed result
// SHIFT   | one operand bit per cycle through the full adder (WIDTH cycles)
// DONE    | single cycle with done=1; sum/cout valid

// Combinational full-adder slice.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_c;

  // Operand B and initial carry as loaded on an accepted start; subtraction
  // is two's complement: a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  serial_adder_fa u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        carry_d = fa_c;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        // cnt_q counts bits already consumed; the last bit is in the cell now.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags decode straight from the state register, so they are glitch-free.
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: random and directed additions, a scoreboard queue
// filled by the driver and drained by a negedge monitor on done.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_r;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     act_start = -1000;
  int     next_ok = 0;
  bit     mon_en = 1'b0;
  logic [W:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole operands.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv, input logic sv);
    logic [W-1:0] bn;
    if (sv) begin
      bn = ~bv;
      return {1'b0, av} + {1'b0, bn} + (W+1)'(1);
    end
    return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
  endfunction

  // Issue one operation; start is held until the edge the DUT can accept it.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv);
    int acc;
    logic [W:0] r;
    logic eff_sub;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = sv;
`else
    eff_sub = 1'b0;
`endif
    a = av; b = bv; cin = cv; sub_r = sv; start = 1'b1;
    acc = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
    while (cyc < acc) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_r = 1'($urandom);
    r = model(av, bv, cv, eff_sub);
    sb_q.push_back('{s: r[W-1:0], c: r[W], cyc: acc + W});
    act_start = acc;
    next_ok = acc + W + 2;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; start = 1'b1;
    a = W'($urandom); b = W'($urandom);
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  32'(sum),  32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
    end
    sb_q.delete();
    act_start = -1000;
    held = '0;
    rst_n = 1'b1; start = 1'b0;
    next_ok = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: busy window, done timing/result, and output hold between results.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("busy", 32'(busy), 32'((cyc >= act_start) && (cyc < act_start + W)));
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("sum",  32'(sum),  32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          held = {e.c, e.s};
        end
      end else begin
        if (sb_q.size() != 0 && sb_q[0].cyc <= cyc)
          chk("done_missing", 32'(done), 32'd1);
        chk("hold", 32'({cout, sum}), 32'(held));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    mon_en = 1'b1;
    idle(3);

    issue(8'h3C, 8'h05, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'hA5, 8'h5A, 1'b1, 1'b0);
    issue(8'h00, 8'h00, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);

    // start while busy is ignored, then a back-to-back start at the minimum period
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    idle(2);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    idle(1);
    start = 1'b0;
    issue(8'h11, 8'h22, 1'b1, 1'b0);
    idle(W + 4);

    // reset in the middle of an addition aborts it
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    idle(3);
    do_reset(1);
    idle(W + 4);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    issue(8'h07, 8'h05, 1'b0, 1'b1);
    issue(8'h33, 8'h33, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 3));
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    idle(W + 4);
    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
